// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide adder that reuses one 4-bit adder.
// It adds one nibble per clock, least significant nibble first, and keeps
// the inter-nibble carry in a register. Operands and result use
// valid/ready handshakes.
// Optional macro NIBBLE_ADD_SUB_EN adds a 'sub' port for a-b (two's complement).

module fourBitAdder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_c;

    // Ripple the carry through four full-adder cells.
    always_comb begin
        w_c    = 5'b00000;
        o_s    = 4'b0000;
        w_c[0] = i_ci;
        for (int k = 0; k < 4; k++) begin
            o_s[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
            w_c[k+1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
        end
        o_co = w_c[4];
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_carry;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_add_s;
    logic          w_add_co;
    logic [W-1:0]  w_sum_shift;
    logic [W-1:0]  w_b_load;
    logic          w_c_load;
    logic          w_accept;
    logic          w_last;

    fourBitAdder u_add (
        .i_a  (r_a_sh[3:0]),
        .i_b  (r_b_sh[3:0]),
        .i_ci (r_carry),
        .o_s  (w_add_s),
        .o_co (w_add_co)
    );

    // The new nibble enters at the top; with one nibble it is the whole sum.
    generate
        if (NIBBLES == 1) begin : g_one
            assign w_sum_shift = w_add_s;
        end else begin : g_multi
            assign w_sum_shift = {w_add_s, r_sum[W-1:4]};
        end
    endgenerate

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST);

    // Select the B operand and initial carry to load (subtract inverts B and forces carry-in).
    always_comb begin
`ifdef NIBBLE_ADD_SUB_EN
        if (sub) begin
            w_b_load = ~b;
            w_c_load = 1'b1;
        end else begin
            w_b_load = b;
            w_c_load = cin;
        end
`else
        w_b_load = b;
        w_c_load = cin;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
                else          w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_RUN;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the state register alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: load the operands on accept, then shift and add one nibble per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_shift;
                    r_a_sh  <= r_a_sh >> 3'd4;
                    r_b_sh  <= r_b_sh >> 3'd4;
                    r_carry <= w_add_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) r_cout <= w_add_co;
                    else        r_cout <= r_cout;
                end
                default: begin
                    r_sum  <= r_sum;
                    r_cout <= r_cout;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: a NIBBLES=4 instance for the
// functional scenarios and a NIBBLES=1 instance for the exhaustive nibble check.
// The subtract cases run only when NIBBLE_ADD_SUB_EN is defined.

module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
    logic [15:0] a4 = 16'h0000, b4 = 16'h0000;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [15:0] sum4;
`ifdef NIBBLE_ADD_SUB_EN
    logic        sub4 = 1'b0;
    logic        sub1 = 1'b0;
`endif

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
    logic [3:0]  a1 = 4'h0, b1 = 4'h0;
    logic        in_ready1, out_valid1, cout1, busy1;
    logic [3:0]  sum1;

    logic [16:0] q4[$];
    logic [4:0]  q1[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef NIBBLE_ADD_SUB_EN
        .sub(sub4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef NIBBLE_ADD_SUB_EN
        .sub(sub1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    // Drive one operand set into dut4 at the next edge; returns one negedge after the accept.
    task automatic start_op4(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        @(negedge clk);
        a4 = x; b4 = y; cin4 = c; in_valid4 = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        sub4 = s;
`endif
        q4.push_back(model16(x, y, c, s));
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic wait_done4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release4();
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready4, out_valid4, busy4, cout4, sum4} !== {3'b100, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset4: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 0000",
                     in_ready4, out_valid4, busy4, cout4, sum4);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({in_ready1, out_valid1, busy1, cout1, sum1} !== {3'b100, 1'b0, 4'h0}) begin
            n_err++;
            $display("FAIL reset1: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 0",
                     in_ready1, out_valid1, busy1, cout1, sum1);
        end
    endtask

    task automatic test_add();
        logic [15:0] va[4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hBEEF};
        logic [15:0] vb[4] = '{16'h4321, 16'h0001, 16'h0000, 16'h1357};
        logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] exp;
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op4(va[i], vb[i], vc[i], 1'b0);
            n_vec++;
            if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
                n_err++;
                $display("FAIL add_busy[%0d]: busy=%b in_ready=%b, want 1 0", i, busy4, in_ready4);
            end
            wait_done4(lat);
            n_vec++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL add_latency[%0d]: got %0d, want 4", i, lat);
            end
            exp = q4.pop_front();
            n_vec++;
            if ({cout4, sum4} !== exp) begin
                n_err++;
                $display("FAIL add_result[%0d]: got %b_%h, want %b_%h", i, cout4, sum4, exp[16], exp[15:0]);
            end
            release4();
            n_vec++;
            if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || {cout4, sum4} !== exp) begin
                n_err++;
                $display("FAIL add_release[%0d]: rdy=%b vld=%b res=%b_%h, want 1 0 %b_%h",
                         i, in_ready4, out_valid4, cout4, sum4, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] exp;
        int lat;
        start_op4(16'h00F0, 16'h0010, 1'b0, 1'b0);
        wait_done4(lat);
        exp = q4.pop_front();
        a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({cout4, sum4} !== exp || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: res=%b_%h rdy=%b vld=%b, want %b_%h 0 1",
                         i, cout4, sum4, in_ready4, out_valid4, exp[16], exp[15:0]);
            end
            @(negedge clk);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        n_vec++;
        if (in_ready4 !== 1'b1 || busy4 !== 1'b0 || {cout4, sum4} !== exp) begin
            n_err++;
            $display("FAIL bp_idle: rdy=%b busy=%b res=%b_%h, want 1 0 %b_%h",
                     in_ready4, busy4, cout4, sum4, exp[16], exp[15:0]);
        end
        q4.push_back(model16(16'hAAAA, 16'h5555, 1'b0, 1'b0));
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_done4(lat);
        exp = q4.pop_front();
        n_vec++;
        if (lat !== 4 || {cout4, sum4} !== exp) begin
            n_err++;
            $display("FAIL bp_next: lat=%0d res=%b_%h, want 4 %b_%h", lat, cout4, sum4, exp[16], exp[15:0]);
        end
        release4();
    endtask

    task automatic test_reset_mid_run();
        logic [16:0] exp;
        int lat;
        start_op4(16'h8888, 16'h8888, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp = q4.pop_front();
        n_vec++;
        if ({in_ready4, out_valid4, busy4, cout4, sum4} !== {3'b100, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 0000",
                     in_ready4, out_valid4, busy4, cout4, sum4);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op4(16'h0F0F, 16'h7070, 1'b1, 1'b0);
        wait_done4(lat);
        exp = q4.pop_front();
        n_vec++;
        if (lat !== 4 || {cout4, sum4} !== exp) begin
            n_err++;
            $display("FAIL reset_recover: lat=%0d res=%b_%h, want 4 %b_%h", lat, cout4, sum4, exp[16], exp[15:0]);
        end
        release4();
    endtask

    task automatic test_exhaustive_n1();
        logic [4:0] exp;
        logic [4:0] xa, xb;
        int lat;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    xa = 5'(i); xb = 5'(j);
                    @(negedge clk);
                    a1 = xa[3:0]; b1 = xb[3:0]; cin1 = c[0]; in_valid1 = 1'b1;
                    q1.push_back(xa + xb + {4'd0, c[0]});
                    @(negedge clk);
                    in_valid1 = 1'b0;
                    lat = 0;
                    while (!out_valid1 && lat < 10) begin
                        @(negedge clk);
                        lat++;
                    end
                    exp = q1.pop_front();
                    n_vec++;
                    if (lat !== 1 || {cout1, sum1} !== exp) begin
                        n_err++;
                        $display("FAIL n1_add a=%h b=%h c=%0d: lat=%0d res=%b_%h, want 1 %b_%h",
                                 i, j, c, lat, cout1, sum1, exp[4], exp[3:0]);
                    end
                    out_ready1 = 1'b1;
                    @(negedge clk);
                    out_ready1 = 1'b0;
                end
            end
        end
    endtask

`ifdef NIBBLE_ADD_SUB_EN
    task automatic test_sub();
        logic [15:0] va[3] = '{16'h0005, 16'h0007, 16'h1234};
        logic [15:0] vb[3] = '{16'h0007, 16'h0005, 16'h1234};
        logic [16:0] want[3] = '{17'h0FFFE, 17'h10002, 17'h10000};
        logic [16:0] exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op4(va[i], vb[i], 1'b0, 1'b1);
            wait_done4(lat);
            exp = q4.pop_front();
            n_vec++;
            if (lat !== 4 || {cout4, sum4} !== exp || exp !== want[i]) begin
                n_err++;
                $display("FAIL sub[%0d]: lat=%0d res=%b_%h, want 4 %b_%h", i, lat, cout4, sum4, want[i][16], want[i][15:0]);
            end
            release4();
        end
        sub4 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
        test_exhaustive_n1();
`ifdef NIBBLE_ADD_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
